updown_counter_n: RTL and testbench

Parametrised up/down counter, successor to the fixed 3-bit clk/en/dir counter.

---
 rtl/updown_counter_n.sv | 94 +++++++++
 tb/tb_updown_counter_n.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with programmable modulus and step, synchronous load,
// wrap or saturate mode, registered terminal-count pulse and sticky overflow flag.
module updown_counter_n #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int STEP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic              sat,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf,
    output logic              at_max,
    output logic              at_zero
);

    localparam int                     RW    = WIDTH + 2;
    localparam logic signed [RW-1:0]   MAX_S = RW'(MAX_VAL);
    localparam logic [WIDTH-1:0]       MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]       MOD_W = WIDTH'(MAX_VAL + 1);

    generate
        if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1 || 2**STEP_W - 1 > MAX_VAL + 1) begin : g_bad_params
            $error("updown_counter_n: illegal WIDTH/MAX_VAL/STEP_W combination");
        end
    endgenerate

    logic [WIDTH-1:0]     count_q, count_d;
    logic                 tc_q, tc_d;
    logic                 ovf_q, ovf_d;

    logic signed [RW-1:0] cnt_s, step_s, r;
    logic [WIDTH-1:0]     r_lo, wrap_val, sat_val, load_clamped;
    logic                 bnd_hi, bnd_lo, bnd;

    // Unbounded result carries two extra bits: one for sign, one for overshoot above MAX_VAL.
    always_comb begin
        cnt_s  = signed'({2'b00, count_q});
        step_s = signed'({{(RW-STEP_W){1'b0}}, step});
        r      = dir ? (cnt_s - step_s) : (cnt_s + step_s);
        r_lo   = r[WIDTH-1:0];
        bnd_hi = (r > MAX_S);
        bnd_lo = r[RW-1];
        bnd    = bnd_hi | bnd_lo;
    end

    // Low-bit arithmetic is exact because the corrected value always lands in 0..MAX_VAL.
    always_comb begin
        wrap_val     = bnd_hi ? (r_lo - MOD_W) : (bnd_lo ? (r_lo + MOD_W) : r_lo);
        sat_val      = bnd_hi ? MAX_W : (bnd_lo ? '0 : r_lo);
        load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~clr_ovf;
        if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            count_d = sat ? sat_val : wrap_val;
            tc_d    = bnd;
            ovf_d   = ovf_d | bnd;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign at_max  = (count_q == MAX_W);
    assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
// Self-checking bench for updown_counter_n (WIDTH=4, MAX_VAL=9, STEP_W=3): directed
// scenarios with literal expectations plus randomized traffic against an integer model.
module tb_updown_counter_n;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 9;
    localparam int STEP_W  = 3;
    localparam int MODULUS = MAX_VAL + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              dir = 1'b0;
    logic [STEP_W-1:0] step = '0;
    logic              sat = 1'b0;
    logic              load = 1'b0;
    logic [WIDTH-1:0]  load_val = '0;
    logic              clr_ovf = 1'b0;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              ovf;
    logic              at_max;
    logic              at_zero;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    int m_count = 0;
    int m_tc    = 0;
    int m_ovf   = 0;

    updown_counter_n #(
        .WIDTH  (WIDTH),
        .MAX_VAL(MAX_VAL),
        .STEP_W (STEP_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .dir     (dir),
        .step    (step),
        .sat     (sat),
        .load    (load),
        .load_val(load_val),
        .clr_ovf (clr_ovf),
        .count   (count),
        .tc      (tc),
        .ovf     (ovf),
        .at_max  (at_max),
        .at_zero (at_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: integer arithmetic with true modulo or clamping.
    always @(posedge clk or posedge rst) begin
        int r;
        bit b;
        if (rst) begin
            m_count = 0;
            m_tc    = 0;
            m_ovf   = 0;
        end else if (load) begin
            m_count = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
            m_tc    = 0;
            if (clr_ovf) m_ovf = 0;
        end else if (en) begin
            r = dir ? (m_count - int'(step)) : (m_count + int'(step));
            b = (r > MAX_VAL) || (r < 0);
            if (sat) m_count = (r > MAX_VAL) ? MAX_VAL : ((r < 0) ? 0 : r);
            else     m_count = ((r % MODULUS) + MODULUS) % MODULUS;
            m_tc = b ? 1 : 0;
            if (b)            m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end else begin
            m_tc = 0;
            if (clr_ovf) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("count",   int'(count),   m_count);
            check("tc",      int'(tc),      m_tc);
            check("ovf",     int'(ovf),     m_ovf);
            check("at_max",  int'(at_max),  (m_count == MAX_VAL) ? 1 : 0);
            check("at_zero", int'(at_zero), (m_count == 0) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit e, input bit d, input int s, input bit sa,
                         input bit ld, input int lv, input bit clr);
        en       = e;
        dir      = d;
        step     = STEP_W'(s);
        sat      = sa;
        load     = ld;
        load_val = WIDTH'(lv);
        clr_ovf  = clr;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[5];
        int exp_tc[5];

        #1 rst = 1'b1;
        tick();
        tick();
        check("reset_count", int'(count), 0);
        check("reset_tc",    int'(tc),    0);
        check("reset_ovf",   int'(ovf),   0);
        rst     = 1'b0;
        started = 1'b1;

        // Reset mid-count
        drive(0, 0, 0, 0, 1, 5, 0);
        tick();
        check("load5", int'(count), 5);
        drive(1, 0, 1, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_tc",    int'(tc),    0);
        check("async_rst_ovf",   int'(ovf),   0);
        tick();
        tick();
        check("rst_hold_count", int'(count), 0);
        rst = 1'b0;

        // Wrap up by 1 from 0
        drive(1, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("wrap_up_count", int'(count), i % 10);
            check("wrap_up_tc",    int'(tc),    (i == 10) ? 1 : 0);
            if (i == 9) check("wrap_up_at_max", int'(at_max), 1);
        end
        check("wrap_up_ovf", int'(ovf), 1);

        // Wrap down by 3 from 1
        drive(0, 0, 0, 0, 1, 1, 0);
        tick();
        exp_seq = '{8, 5, 2, 9, 6};
        exp_tc  = '{1, 0, 0, 1, 0};
        drive(1, 1, 3, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wrap_dn_count", int'(count), exp_seq[i]);
            check("wrap_dn_tc",    int'(tc),    exp_tc[i]);
        end

        // Saturate up by 4 from 3, then down
        drive(0, 0, 0, 1, 1, 3, 0);
        tick();
        exp_seq = '{7, 9, 9, 9, 0};
        exp_tc  = '{0, 1, 1, 1, 0};
        drive(1, 0, 4, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sat_up_count", int'(count), exp_seq[i]);
            check("sat_up_tc",    int'(tc),    exp_tc[i]);
        end
        exp_seq = '{5, 1, 0, 0, 0};
        exp_tc  = '{0, 0, 1, 0, 0};
        drive(1, 1, 4, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_dn_count", int'(count), exp_seq[i]);
            check("sat_dn_tc",    int'(tc),    exp_tc[i]);
        end
        check("sat_dn_at_zero", int'(at_zero), 1);

        // Load priority and clamp
        drive(1, 1, 2, 0, 1, 14, 0);
        tick();
        check("load_clamp_count", int'(count), 9);
        check("load_clamp_tc",    int'(tc),    0);
        drive(1, 0, 1, 0, 0, 0, 0);
        tick();
        check("after_clamp_count", int'(count), 0);
        check("after_clamp_tc",    int'(tc),    1);

        // ovf clear, set-wins, step=0 hold
        check("ovf_before_clr", int'(ovf), 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        check("ovf_cleared", int'(ovf), 0);
        drive(1, 1, 1, 0, 0, 0, 1);
        tick();
        check("ovf_set_wins", int'(ovf),   1);
        check("ovf_set_count", int'(count), 9);
        check("ovf_set_tc",   int'(tc),    1);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        check("step0_count", int'(count), 9);
        check("step0_tc",    int'(tc),    0);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #1 rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
